match_controller: RTL and testbench

Round/match sequencer that sits directly downstream of the snake collision checker. It consumes the eaten1/eaten2/won/lost/draw flags and keeps per-round point scores and per-match round wins. It also generates new-point spawn requests and drives the game_active level that gates the game stage. Its states are IDLE, PLAY, RESULT and OVER.

---
 rtl/match_controller.sv | 146 ++++++++++++++
 tb/tb_match_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Round/match sequencer fed by the collision checker: tracks per-round points,
// per-match round wins, point spawn requests and the game_active gate.
module match_controller #(
    parameter int SCORE_W    = 8,
    parameter int ROUND_W    = 4,
    parameter int WIN_ROUNDS = 3,
    parameter int HOLD_TICKS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick,
    input  logic               eaten1,
    input  logic               eaten2,
    input  logic               won,
    input  logic               lost,
    input  logic               draw,
    output logic               game_active,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [ROUND_W-1:0] rounds1,
    output logic [ROUND_W-1:0] rounds2,
    output logic [1:0]         result,
    output logic               result_valid,
    output logic               match_over,
    output logic               point_req
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {IDLE, PLAY, RESULT, OVER} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [ROUND_W-1:0] rounds1_q, rounds1_d, rounds2_q, rounds2_d;
    logic [1:0]         result_q, result_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               eaten1_q, eaten2_q;
    logic               point_req_q, point_req_d;

    logic               edge1, edge2;
    logic [HOLD_W-1:0]  holdInc;
    logic               matchDecided;

    assign edge1        = eaten1 & ~eaten1_q;
    assign edge2        = eaten2 & ~eaten2_q;
    assign holdInc      = hold_q + 1'b1;
    assign matchDecided = (rounds1_q == ROUND_W'(WIN_ROUNDS)) ||
                          (rounds2_q == ROUND_W'(WIN_ROUNDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            score1_q    <= '0;
            score2_q    <= '0;
            rounds1_q   <= '0;
            rounds2_q   <= '0;
            result_q    <= '0;
            hold_q      <= '0;
            eaten1_q    <= 1'b0;
            eaten2_q    <= 1'b0;
            point_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            rounds1_q   <= rounds1_d;
            rounds2_q   <= rounds2_d;
            result_q    <= result_d;
            hold_q      <= hold_d;
            eaten1_q    <= eaten1;
            eaten2_q    <= eaten2;
            point_req_q <= point_req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        rounds1_d   = rounds1_q;
        rounds2_d   = rounds2_q;
        result_d    = result_q;
        hold_d      = hold_q;
        point_req_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = PLAY;
                    score1_d = '0;
                    score2_d = '0;
                    result_d = 2'd0;
                end
            end
            PLAY: begin
                // Eaten edges are scored even in the cycle an outcome arrives.
                if (edge1 && !(&score1_q)) score1_d = score1_q + 1'b1;
                if (edge2 && !(&score2_q)) score2_d = score2_q + 1'b1;
                point_req_d = edge1 | edge2;
                if (draw || lost || won) begin
                    state_d = RESULT;
                    hold_d  = '0;
                    if (draw) begin
                        result_d = 2'd3;
                    end else if (lost) begin
                        result_d = 2'd2;
                        if (!(&rounds2_q)) rounds2_d = rounds2_q + 1'b1;
                    end else begin
                        result_d = 2'd1;
                        if (!(&rounds1_q)) rounds1_d = rounds1_q + 1'b1;
                    end
                end
            end
            RESULT: begin
                if (tick) begin
                    hold_d = holdInc;
                    if (holdInc == HOLD_W'(HOLD_TICKS))
                        state_d = matchDecided ? OVER : IDLE;
                end
            end
            OVER: begin
                if (start) begin
                    state_d   = PLAY;
                    score1_d  = '0;
                    score2_d  = '0;
                    rounds1_d = '0;
                    rounds2_d = '0;
                    result_d  = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign game_active  = (state_q == PLAY);
    assign result_valid = (state_q == RESULT) || (state_q == OVER);
    assign match_over   = (state_q == OVER);
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign rounds1      = rounds1_q;
    assign rounds2      = rounds2_q;
    assign result       = result_q;
    assign point_req    = point_req_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed vector table, hand-built
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_match_controller;

    localparam int HOLD = 16;
    localparam int WINS = 3;

    logic clk, rst, start, tick, eaten1, eaten2, won, lost, draw;
    logic       gameActive, resultValid, matchOver, pointReq;
    logic [7:0] score1, score2;
    logic [3:0] rounds1, rounds2;
    logic [1:0] result;

    logic       smallGa, smallRv, smallMo, smallPr;
    logic [1:0] smallS1, smallS2, smallRes;
    logic [3:0] smallR1, smallR2;

    int checks = 0;
    int errors = 0;

    match_controller dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick),
        .eaten1(eaten1), .eaten2(eaten2), .won(won), .lost(lost), .draw(draw),
        .game_active(gameActive), .score1(score1), .score2(score2),
        .rounds1(rounds1), .rounds2(rounds2), .result(result),
        .result_valid(resultValid), .match_over(matchOver), .point_req(pointReq)
    );

    // Narrow-score instance sharing the same stimulus, used for saturation.
    match_controller #(.SCORE_W(2)) dutSmall (
        .clk(clk), .rst(rst), .start(start), .tick(tick),
        .eaten1(eaten1), .eaten2(eaten2), .won(won), .lost(lost), .draw(draw),
        .game_active(smallGa), .score1(smallS1), .score2(smallS2),
        .rounds1(smallR1), .rounds2(smallR2), .result(smallRes),
        .result_valid(smallRv), .match_over(smallMo), .point_req(smallPr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string phase = "idle";
    int mScore1 = 0, mScore2 = 0, mSmall1 = 0, mSmall2 = 0;
    int mRounds1 = 0, mRounds2 = 0, mResult = 0, mHold = 0, mPr = 0;
    int mPrev1 = 0, mPrev2 = 0;

    function automatic int satInc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic clearRound();
        mScore1 = 0; mScore2 = 0; mSmall1 = 0; mSmall2 = 0; mResult = 0;
    endtask

    task automatic modelStep();
        int rise1, rise2;
        rise1 = (eaten1 && mPrev1 == 0) ? 1 : 0;
        rise2 = (eaten2 && mPrev2 == 0) ? 1 : 0;
        mPr = 0;
        if (rst) begin
            phase = "idle";
            clearRound();
            mRounds1 = 0; mRounds2 = 0; mHold = 0;
            rise1 = 0; rise2 = 0;
        end else if (phase == "idle") begin
            if (start) begin phase = "play"; clearRound(); end
        end else if (phase == "play") begin
            if (rise1 != 0) begin mScore1 = satInc(mScore1, 255); mSmall1 = satInc(mSmall1, 3); end
            if (rise2 != 0) begin mScore2 = satInc(mScore2, 255); mSmall2 = satInc(mSmall2, 3); end
            mPr = rise1 | rise2;
            if (draw || lost || won) begin
                phase = "show";
                mHold = 0;
                if (draw)      mResult = 3;
                else if (lost) begin mResult = 2; mRounds2 = satInc(mRounds2, 15); end
                else           begin mResult = 1; mRounds1 = satInc(mRounds1, 15); end
            end
        end else if (phase == "show") begin
            if (tick) begin
                mHold++;
                if (mHold == HOLD)
                    phase = (mRounds1 == WINS || mRounds2 == WINS) ? "done" : "idle";
            end
        end else begin
            if (start) begin
                phase = "play"; clearRound(); mRounds1 = 0; mRounds2 = 0;
            end
        end
        mPrev1 = eaten1 ? 1 : 0;
        mPrev2 = eaten2 ? 1 : 0;
    endtask

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input int iRst, input int iStart, input int iTick,
                                 input int iE1, input int iE2, input int iWon,
                                 input int iLost, input int iDraw);
        rst = (iRst != 0); start = (iStart != 0); tick = (iTick != 0);
        eaten1 = (iE1 != 0); eaten2 = (iE2 != 0);
        won = (iWon != 0); lost = (iLost != 0); draw = (iDraw != 0);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput();
        checkField("game_active", int'(gameActive), (phase == "play") ? 1 : 0);
        checkField("score1", int'(score1), mScore1);
        checkField("score2", int'(score2), mScore2);
        checkField("rounds1", int'(rounds1), mRounds1);
        checkField("rounds2", int'(rounds2), mRounds2);
        checkField("result", int'(result), mResult);
        checkField("result_valid", int'(resultValid), (phase == "show" || phase == "done") ? 1 : 0);
        checkField("match_over", int'(matchOver), (phase == "done") ? 1 : 0);
        checkField("point_req", int'(pointReq), mPr);
        checkField("small score1", int'(smallS1), mSmall1);
        checkField("small score2", int'(smallS2), mSmall2);
    endtask

    task automatic runCycle(input int iRst, input int iStart, input int iTick,
                            input int iE1, input int iE2, input int iWon,
                            input int iLost, input int iDraw);
        applyStimulus(iRst, iStart, iTick, iE1, iE2, iWon, iLost, iDraw);
        checkOutput();
    endtask

    task automatic holdTicks(input int n);
        for (int i = 0; i < n; i++) begin
            runCycle(0, 0, 1, 0, 0, 0, 0, 0);
            runCycle(0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic playRound(input int iWon, input int iLost, input int iDraw);
        runCycle(0, 1, 0, 0, 0, 0, 0, 0);
        runCycle(0, 0, 0, 0, 0, iWon, iLost, iDraw);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0);
        holdTicks(HOLD);
    endtask

    typedef struct {
        int rst, start, tick, e1, e2, won, lost, draw;
        int ga, s1, s2, r1, r2, res, rv, pr;
    } vec_t;

    vec_t vecs[16];
    int   pulses;
    int   e1Lvl, e2Lvl;

    initial begin
        rst = 1'b1; start = 1'b0; tick = 1'b0; eaten1 = 1'b0; eaten2 = 1'b0;
        won = 1'b0; lost = 1'b0; draw = 1'b0;

        //            rst st tk e1 e2 wn ls dr   ga s1 s2 r1 r2 rs rv pr
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 1, 1, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0, 1};
        vecs[12] = '{0, 1, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 1, 0, 1,  0, 3, 1, 0, 0, 3, 1, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 1, 0, 0,  0, 3, 1, 0, 0, 3, 1, 0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 1, 0, 0, 3, 1, 0};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].tick, vecs[i].e1,
                          vecs[i].e2, vecs[i].won, vecs[i].lost, vecs[i].draw);
            checkField($sformatf("vec%0d game_active", i), int'(gameActive), vecs[i].ga);
            checkField($sformatf("vec%0d score1", i), int'(score1), vecs[i].s1);
            checkField($sformatf("vec%0d score2", i), int'(score2), vecs[i].s2);
            checkField($sformatf("vec%0d rounds1", i), int'(rounds1), vecs[i].r1);
            checkField($sformatf("vec%0d rounds2", i), int'(rounds2), vecs[i].r2);
            checkField($sformatf("vec%0d result", i), int'(result), vecs[i].res);
            checkField($sformatf("vec%0d result_valid", i), int'(resultValid), vecs[i].rv);
            checkField($sformatf("vec%0d point_req", i), int'(pointReq), vecs[i].pr);
            checkField($sformatf("vec%0d small score1", i), int'(smallS1), vecs[i].s1);
        end

        // Draw round ends in IDLE after the hold, result stays visible.
        holdTicks(HOLD);
        checkField("hold exit result_valid", int'(resultValid), 0);
        checkField("hold exit result kept", int'(result), 3);
        checkField("hold exit game_active", int'(gameActive), 0);

        for (int r = 0; r < WINS; r++) playRound(1, 0, 0);
        checkField("three wins rounds1", int'(rounds1), 3);
        checkField("three wins match_over", int'(matchOver), 1);
        checkField("three wins result", int'(result), 1);
        runCycle(0, 1, 0, 0, 0, 0, 0, 0);
        checkField("over start rounds1", int'(rounds1), 0);
        checkField("over start game_active", int'(gameActive), 1);

        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            runCycle(0, 0, 0, 1, 0, 0, 0, 0);
            if (pointReq) pulses++;
            runCycle(0, 0, 0, 0, 0, 0, 0, 0);
            if (pointReq) pulses++;
        end
        checkField("saturation point_req pulses", pulses, 5);
        checkField("wide score1 after 5 edges", int'(score1), 5);
        checkField("narrow score1 saturated", int'(smallS1), 3);

        runCycle(0, 0, 0, 0, 0, 0, 1, 0);
        holdTicks(7);
        runCycle(1, 0, 0, 0, 0, 0, 0, 0);
        checkField("rst in RESULT packed outputs",
                   int'({gameActive, score1, score2, rounds1, rounds2, result,
                         resultValid, matchOver, pointReq}), 0);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0);

        for (int r = 0; r < WINS; r++) playRound(0, 1, 0);
        checkField("three losses match_over", int'(matchOver), 1);
        checkField("three losses rounds2", int'(rounds2), 3);
        runCycle(1, 0, 0, 0, 0, 0, 0, 0);
        checkField("rst in OVER packed outputs",
                   int'({gameActive, score1, score2, rounds1, rounds2, result,
                         resultValid, matchOver, pointReq}), 0);
        runCycle(0, 0, 0, 1, 1, 1, 0, 0);
        checkField("idle eaten score1", int'(score1), 0);
        checkField("idle eaten point_req", int'(pointReq), 0);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; eaten levels toggle occasionally to form edges.
        e1Lvl = 0;
        e2Lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) e1Lvl = 1 - e1Lvl;
            if ($urandom_range(3) == 0) e2Lvl = 1 - e2Lvl;
            runCycle(($urandom_range(299) == 0) ? 1 : 0,
                     ($urandom_range(9) == 0) ? 1 : 0,
                     ($urandom_range(2) == 0) ? 1 : 0,
                     e1Lvl, e2Lvl,
                     ($urandom_range(15) == 0) ? 1 : 0,
                     ($urandom_range(15) == 0) ? 1 : 0,
                     ($urandom_range(15) == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
